// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: control bit positions and Hack opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pipe_pkg;

  // Bit positions inside the 6-bit ctrl word {zx,nx,zy,ny,f,no}.
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  // The 18 Hack ALU computations.
  localparam logic [5:0] OP_ZERO    = 6'b101010;
  localparam logic [5:0] OP_ONE     = 6'b111111;
  localparam logic [5:0] OP_NEG1    = 6'b111010;
  localparam logic [5:0] OP_X       = 6'b001100;
  localparam logic [5:0] OP_Y       = 6'b110000;
  localparam logic [5:0] OP_NOTX    = 6'b001101;
  localparam logic [5:0] OP_NOTY    = 6'b110001;
  localparam logic [5:0] OP_NEGX    = 6'b001111;
  localparam logic [5:0] OP_NEGY    = 6'b110011;
  localparam logic [5:0] OP_XPLUS1  = 6'b011111;
  localparam logic [5:0] OP_YPLUS1  = 6'b110111;
  localparam logic [5:0] OP_XMINUS1 = 6'b001110;
  localparam logic [5:0] OP_YMINUS1 = 6'b110010;
  localparam logic [5:0] OP_XPLUSY  = 6'b000010;
  localparam logic [5:0] OP_XMINUSY = 6'b010011;
  localparam logic [5:0] OP_YMINUSX = 6'b000111;
  localparam logic [5:0] OP_XANDY   = 6'b000000;
  localparam logic [5:0] OP_XORY    = 6'b010101;

endpackage

// File: rtl/alu_pipe_stage.sv
// Generic valid/ready pipeline register holding one W-bit payload.
// Latency: 1 cycle.
// Backpressure: in_ready = ~out_valid | out_ready; payload holds while stalled.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module alu_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         en;

  always_comb begin
    en      = ~valid_q | out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid;
      // Payload only moves on a real transfer, so bubbles keep the old value.
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack ALU (preset, then compute) with tag pass-through.
// Latency: accepted at edge N, result valid after edge N+1; 1 op/cycle.
// Backpressure: full valid/ready; in_ready depends only on out_ready and state.
// Ports: clk, rst_n; in_valid/in_ready/x/y/ctrl/in_tag; out_valid/out_ready/out/zr/ng/out_tag.
// Optional: define ALU_PIPE_CARRY_EN to add co/ov (carry and signed overflow of xs+ys).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_PIPE_CARRY_EN
  ,
  output logic             co,
  output logic             ov
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic             f;
    logic             no;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zr;
    logic             ng;
`ifdef ALU_PIPE_CARRY_EN
    logic             co;
    logic             ov;
`endif
    logic [TAG_W-1:0] tag;
  } s2_t;

  s1_t s1_in, s1_out;
  s2_t s2_in, s2_out;
  logic s1_valid, s2_ready;

  logic [WIDTH-1:0] xz, yz, r;
`ifdef ALU_PIPE_CARRY_EN
  logic [WIDTH:0] sum;
`else
  logic [WIDTH-1:0] sum;
`endif

  // Stage 1: zero/negate presets on the raw operands.
  always_comb begin
    xz        = ctrl[CTRL_ZX] ? '0 : x;
    yz        = ctrl[CTRL_ZY] ? '0 : y;
    s1_in     = '0;
    s1_in.xs  = ctrl[CTRL_NX] ? ~xz : xz;
    s1_in.ys  = ctrl[CTRL_NY] ? ~yz : yz;
    s1_in.f   = ctrl[CTRL_F];
    s1_in.no  = ctrl[CTRL_NO];
    s1_in.tag = in_tag;
  end

  // Stage 2: function select, output negate, flags from the final value.
  always_comb begin
`ifdef ALU_PIPE_CARRY_EN
    sum = {1'b0, s1_out.xs} + {1'b0, s1_out.ys};
    r   = s1_out.f ? sum[WIDTH-1:0] : (s1_out.xs & s1_out.ys);
`else
    sum = s1_out.xs + s1_out.ys;
    r   = s1_out.f ? sum : (s1_out.xs & s1_out.ys);
`endif
    s2_in     = '0;
    s2_in.res = s1_out.no ? ~r : r;
    s2_in.zr  = (s2_in.res == '0);
    s2_in.ng  = s2_in.res[WIDTH-1];
    s2_in.tag = s1_out.tag;
`ifdef ALU_PIPE_CARRY_EN
    // Both flags describe the raw addition, before the 'no' inversion.
    s2_in.co  = s1_out.f & sum[WIDTH];
    s2_in.ov  = s1_out.f & (s1_out.xs[WIDTH-1] == s1_out.ys[WIDTH-1])
                         & (sum[WIDTH-1] != s1_out.xs[WIDTH-1]);
`endif
  end

  alu_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  alu_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out     = s2_out.res;
  assign zr      = s2_out.zr;
  assign ng      = s2_out.ng;
  assign out_tag = s2_out.tag;
`ifdef ALU_PIPE_CARRY_EN
  assign co      = s2_out.co;
  assign ov      = s2_out.ov;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized scoreboard bench for alu_pipe against an arithmetic Hack ALU model.
// Latency: checks 2-cycle accept-to-output latency and back-to-back throughput.
// Backpressure: random and directed out_ready stalls, plus reset mid-stream.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam longint MOD  = 64'd1 << W;
  localparam longint MASK = MOD - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready, zr, ng;
  logic [W-1:0]  x, y, out;
  logic [5:0]    ctrl;
  logic [TW-1:0] in_tag, out_tag;
`ifdef ALU_PIPE_CARRY_EN
  logic          co, ov, co_8, ov_8;
`endif

  // Second, narrow instance for the WIDTH=8 case.
  logic          in_valid_8, in_ready_8, out_valid_8, out_ready_8, zr_8, ng_8;
  logic [7:0]    x_8, y_8, out_8;
  logic [5:0]    ctrl_8;
  logic [TW-1:0] in_tag_8, out_tag_8;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .out_tag(out_tag)
`ifdef ALU_PIPE_CARRY_EN
    , .co(co), .ov(ov)
`endif
  );

  alu_pipe #(.WIDTH(8), .TAG_W(TW)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .x(x_8), .y(y_8), .ctrl(ctrl_8), .in_tag(in_tag_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .out(out_8),
    .zr(zr_8), .ng(ng_8), .out_tag(out_tag_8)
`ifdef ALU_PIPE_CARRY_EN
    , .co(co_8), .ov(ov_8)
`endif
  );

  typedef struct {
    logic [W-1:0]  out;
    logic          zr;
    logic          ng;
    logic [TW-1:0] tag;
    logic          co;
    logic          ov;
  } exp_t;

  exp_t sb[$];
  exp_t seen[$];
  int   seen_cyc[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   rand_rdy = 0;
  logic [TW-1:0] tag_ctr = '0;

  logic [5:0] ops [18] = '{OP_ZERO, OP_ONE, OP_NEG1, OP_X, OP_Y, OP_NOTX,
                           OP_NOTY, OP_NEGX, OP_NEGY, OP_XPLUS1, OP_YPLUS1,
                           OP_XMINUS1, OP_YMINUS1, OP_XPLUSY, OP_XMINUSY,
                           OP_YMINUSX, OP_XANDY, OP_XORY};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Hack ALU as integer arithmetic: bitwise NOT is MASK - v.
  function automatic exp_t model(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                 input logic [5:0] c, input logic [TW-1:0] t);
    exp_t   m;
    longint xv, yv, s, r, sx, sy, ss;
    xv = c[CTRL_ZX] ? 64'd0 : longint'(xi);
    if (c[CTRL_NX]) xv = MASK - xv;
    yv = c[CTRL_ZY] ? 64'd0 : longint'(yi);
    if (c[CTRL_NY]) yv = MASK - yv;
    s = xv + yv;
    r = c[CTRL_F] ? (s % MOD) : (xv & yv);
    if (c[CTRL_NO]) r = MASK - r;
    sx = (xv >= MOD / 2) ? xv - MOD : xv;
    sy = (yv >= MOD / 2) ? yv - MOD : yv;
    ss = sx + sy;
    m.out = r[W-1:0];
    m.zr  = (r == 0);
    m.ng  = (r >= MOD / 2);
    m.tag = t;
    m.co  = c[CTRL_F] && (s >= MOD);
    m.ov  = c[CTRL_F] && ((ss >= MOD / 2) || (ss < -(MOD / 2)));
    return m;
  endfunction

  // Input side of the scoreboard: an accept happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(x, y, ctrl, in_tag));
      acc_cyc.push_back(cyc);
    end
  end

  // Output monitor: compares transfers, stall stability and bubble cleanliness.
  bit   hold_vld = 0;
  exp_t hold;
  always @(negedge clk) begin
    exp_t e, got;
    if (!rst_n) begin
      hold_vld = 0;
    end else begin
      if (hold_vld) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_out", out, hold.out);
        check("stall_flags", {zr, ng}, {hold.zr, hold.ng});
        check("stall_tag", out_tag, hold.tag);
      end
      if (!out_valid) check("bubble_no_x", $isunknown({out, zr, ng, out_tag}), 1'b0);
      got.out = out; got.zr = zr; got.ng = ng; got.tag = out_tag;
`ifdef ALU_PIPE_CARRY_EN
      got.co = co; got.ov = ov;
`else
      got.co = 1'b0; got.ov = 1'b0;
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got tag %0h out %0h with empty scoreboard", out_tag, out);
        end else begin
          e = sb.pop_front();
          check("sb_out", out, e.out);
          check("sb_zr", zr, e.zr);
          check("sb_ng", ng, e.ng);
          check("sb_tag", out_tag, e.tag);
`ifdef ALU_PIPE_CARRY_EN
          check("sb_co", co, e.co);
          check("sb_ov", ov, e.ov);
`endif
        end
        seen.push_back(got);
        seen_cyc.push_back(cyc);
      end
      hold_vld = out_valid && !out_ready;
      hold = got;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic new_op(input bit rand_ctrl);
    x = W'($urandom);
    y = W'($urandom);
    ctrl = rand_ctrl && $urandom_range(0, 1) ? 6'($urandom) : ops[$urandom_range(0, 17)];
    in_tag = tag_ctr;
    tag_ctr = tag_ctr + 1'b1;
  endtask

  // n cycles of traffic; an offered op stays on the bus until accepted.
  task automatic run(input int n, input bit rand_valid, output int acc);
    bit a;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (!in_valid && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        new_op(rand_valid);
        in_valid = 1'b1;
      end
      @(negedge clk);
      a = in_valid && in_ready;
      @(posedge clk); #1;
      if (a) begin acc++; in_valid = 1'b0; end
    end
  endtask

  task automatic send(input logic [W-1:0] xi, input logic [W-1:0] yi,
                      input logic [5:0] c, input logic [TW-1:0] t);
    bit a;
    int n;
    x = xi; y = yi; ctrl = c; in_tag = t; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); a = in_ready;
      @(posedge clk); #1; n++;
    end while (!a && n < 100);
    if (!a) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic flush();
    int n, acc;
    n = 0;
    while (in_valid && n < 100) begin run(1, 0, acc); n++; end
    if (in_valid) check("flush_timeout", 1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int s0, a0, acc, acc2, n;
    logic [W-1:0] exp_stream [5];
    in_valid = 0; out_ready = 0; x = '0; y = '0; ctrl = '0; in_tag = '0;
    in_valid_8 = 0; out_ready_8 = 1; x_8 = '0; y_8 = '0; ctrl_8 = '0; in_tag_8 = '0;

    // Reset state.
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_flags", {zr, ng}, 2'b00);
    check("rst_tag", out_tag, '0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed back-to-back stream.
    out_ready = 1'b1;
    s0 = seen.size(); a0 = acc_cyc.size();
    send(16'h0011, 16'h0003, OP_XPLUSY,  4'd1);
    send(16'h0011, 16'h0003, OP_XMINUSY, 4'd2);
    send(16'h0011, 16'h0003, OP_YMINUSX, 4'd3);
    send(16'h0011, 16'h0003, OP_XANDY,   4'd4);
    send(16'h0011, 16'h0003, OP_XORY,    4'd5);
    drain();
    exp_stream = '{16'h0014, 16'h000E, 16'hFFF2, 16'h0001, 16'h0013};
    check("stream_count", seen.size() - s0, 5);
    if (seen.size() - s0 == 5) begin
      check("stream_latency", seen_cyc[s0] - acc_cyc[a0], 2);
      for (int k = 0; k < 5; k++) begin
        check("stream_out", seen[s0 + k].out, exp_stream[k]);
        check("stream_tag", seen[s0 + k].tag, k + 1);
        check("stream_ng", seen[s0 + k].ng, k == 2);
        check("stream_b2b", seen_cyc[s0 + k] - seen_cyc[s0], k);
      end
    end

    // Constant outputs and flags.
    s0 = seen.size();
    send(16'h0000, 16'hFFFF, OP_ZERO, 4'd6);
    send(16'h0000, 16'hFFFF, 6'b111010, 4'd7);
    drain();
    check("const_count", seen.size() - s0, 2);
    if (seen.size() - s0 == 2) begin
      check("zero_out", seen[s0].out, 16'h0000);
      check("zero_flags", {seen[s0].zr, seen[s0].ng}, 2'b10);
      check("neg1_out", seen[s0 + 1].out, 16'hFFFF);
      check("neg1_flags", {seen[s0 + 1].zr, seen[s0 + 1].ng}, 2'b01);
    end

`ifdef ALU_PIPE_CARRY_EN
    s0 = seen.size();
    send(16'hFFFF, 16'h0001, OP_XPLUSY, 4'd8);
    send(16'h7FFF, 16'h0001, OP_XPLUSY, 4'd9);
    drain();
    check("carry_count", seen.size() - s0, 2);
    if (seen.size() - s0 == 2) begin
      check("carry_out", seen[s0].out, 16'h0000);
      check("carry_zr_co_ov", {seen[s0].zr, seen[s0].co, seen[s0].ov}, 3'b110);
      check("ovf_out", seen[s0 + 1].out, 16'h8000);
      check("ovf_ng_co_ov", {seen[s0 + 1].ng, seen[s0 + 1].co, seen[s0 + 1].ov}, 3'b101);
    end
`endif

    // Backpressure: 5 stalled cycles with continuous offers.
    s0 = seen.size(); a0 = acc_cyc.size();
    out_ready = 1'b0;
    run(5, 0, acc);
    check("bp_accepts", acc, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    run(6, 0, acc2);
    flush();
    drain();
    check("bp_no_loss", seen.size() - s0, acc_cyc.size() - a0);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    run(2, 0, acc);
    check("rst_inflight", acc, 2);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 check("rst_mid_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rst_mid_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    s0 = seen.size();
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_stale", seen.size() - s0, 0);
    check("rst_no_stale_valid", out_valid, 1'b0);

    // Random traffic with random backpressure.
    s0 = seen.size(); a0 = acc_cyc.size();
    rand_rdy = 1;
    run(600, 1, acc);
    rand_rdy = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    flush();
    drain();
    check("rand_count", seen.size() - s0, acc_cyc.size() - a0);

    // WIDTH=8 instance.
    x_8 = 8'h11; y_8 = 8'h03; ctrl_8 = OP_XMINUSY; in_tag_8 = 4'hA; in_valid_8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready", in_ready_8, 1'b1);
    @(posedge clk); #1 in_valid_8 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid_8 && n < 20);
    check("w8_valid", out_valid_8, 1'b1);
    check("w8_out", out_8, 8'h0E);
    check("w8_flags", {zr_8, ng_8}, 2'b00);
    check("w8_tag", out_tag_8, 4'hA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
